// File: rtl/freq_m_multi.sv
// Multi-channel frequency meter: counts synchronised rising edges per channel over a
// programmable gate and latches all counts together. Define FREQ_M_MINMAX_EN for running min/max.
module freq_m_multi #(
    parameter int CH       = 2,
    parameter int CNT_W    = 32,
    parameter int GATE_W   = 32,
    parameter int SYNC_STG = 2
) (
    input  logic                clk_base,
    input  logic                rst_n,
    input  logic                en,
    input  logic [GATE_W-1:0]   gate_len,
    input  logic [CH-1:0]       clk_in,
`ifdef FREQ_M_MINMAX_EN
    input  logic                clr_minmax,
    output logic [CH*CNT_W-1:0] fmax_mem,
    output logic [CH*CNT_W-1:0] fmin_mem,
`endif
    output logic [CH*CNT_W-1:0] freq_mem,
    output logic [CH-1:0]       ovf,
    output logic                valid,
    output logic                busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          w_gate_start;
    logic                          w_gate_end;
    logic                          w_count;
    logic                          w_abort;
    logic                          w_gate_last;
    logic [GATE_W-1:0]             w_len_sel;
    logic [GATE_W-1:0]             r_gate_cnt;
    logic [GATE_W-1:0]             r_gate_len;
    logic [SYNC_STG-1:0][CH-1:0]   r_sync;
    logic [CH-1:0]                 r_edge_q;
    logic [CH-1:0]                 w_edge_det;
    logic [CH-1:0][CNT_W-1:0]      r_edge_cnt;
    logic [CH-1:0]                 r_sat;
    logic [CH-1:0]                 w_cnt_full;
    logic [CH-1:0][CNT_W-1:0]      w_res;
    logic [CH-1:0]                 w_res_ovf;
    logic [CH-1:0][CNT_W-1:0]      r_freq;
    logic [CH-1:0]                 r_ovf;
    logic                          r_valid;

    // Synchroniser chain plus one edge-detect flop; these run regardless of state.
    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_edge_q <= '0;
        end else begin
            r_sync[0] <= clk_in;
            for (int s = 1; s < SYNC_STG; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_edge_q <= r_sync[SYNC_STG-1];
        end
    end

    assign w_edge_det  = r_sync[SYNC_STG-1] & ~r_edge_q;
    assign w_len_sel   = (gate_len == '0) ? GATE_W'(1) : gate_len;
    assign w_gate_last = (r_gate_cnt == r_gate_len - GATE_W'(1));

    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort has priority over a gate end: dropping en in the last cycle discards the gate.
    always_comb begin
        w_state_nxt  = r_state;
        w_gate_start = 1'b0;
        w_gate_end   = 1'b0;
        w_count      = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt  = S_RUN;
                    w_gate_start = 1'b1;
                end
            end
            S_RUN: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (w_gate_last) begin
                    w_gate_end   = 1'b1;
                    w_gate_start = 1'b1;
                end else begin
                    w_count = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt <= '0;
            r_gate_len <= '0;
        end else if (w_gate_start) begin
            r_gate_cnt <= '0;
            r_gate_len <= w_len_sel;
        end else if (w_count) begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
        end else if (w_abort) begin
            r_gate_cnt <= '0;
        end
    end

    // The last gate cycle's edge is folded into the result instead of the counter.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign w_cnt_full[i] = (r_edge_cnt[i] == CNT_MAX);
        assign w_res[i]      = w_cnt_full[i] ? CNT_MAX : r_edge_cnt[i] + CNT_W'(w_edge_det[i]);
        assign w_res_ovf[i]  = r_sat[i] | (w_cnt_full[i] & w_edge_det[i]);
    end

    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
            r_sat      <= '0;
        end else if (w_gate_start || w_abort) begin
            r_edge_cnt <= '0;
            r_sat      <= '0;
        end else if (w_count) begin
            for (int i = 0; i < CH; i++) begin
                if (w_edge_det[i]) begin
                    if (w_cnt_full[i]) begin
                        r_sat[i] <= 1'b1;
                    end else begin
                        r_edge_cnt[i] <= r_edge_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            r_freq  <= '0;
            r_ovf   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_gate_end;
            if (w_gate_end) begin
                r_freq <= w_res;
                r_ovf  <= w_res_ovf;
            end
        end
    end

`ifdef FREQ_M_MINMAX_EN
    logic [CH-1:0][CNT_W-1:0] r_fmax;
    logic [CH-1:0][CNT_W-1:0] r_fmin;

    // Cleared values (0 / all-ones) make the first result load both naturally.
    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            r_fmax <= '0;
            r_fmin <= '1;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (w_gate_end) begin
                    if (clr_minmax || (w_res[i] > r_fmax[i])) begin
                        r_fmax[i] <= w_res[i];
                    end
                    if (clr_minmax || (w_res[i] < r_fmin[i])) begin
                        r_fmin[i] <= w_res[i];
                    end
                end else if (clr_minmax) begin
                    r_fmax[i] <= '0;
                    r_fmin[i] <= '1;
                end
            end
        end
    end

    assign fmax_mem = r_fmax;
    assign fmin_mem = r_fmin;
`endif

    assign freq_mem = r_freq;
    assign ovf      = r_ovf;
    assign valid    = r_valid;
    assign busy     = (r_state == S_RUN);

endmodule
